// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and RAM mode constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [3:0] MODE_FETCH = 4'b0100;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
endpackage

// File: rtl/mem_mode_check.sv
// mem_mode_check: flags whether a {funct3, we} RAM mode is a legal load or store
module mem_mode_check
    import mem_arb_pkg::*;
(
    input  logic [3:0] i_mode,
    output logic       o_legal
);
    logic [2:0] w_f3;
    assign w_f3    = i_mode[3:1];
    assign o_legal = i_mode[0] ? (w_f3 == F3_SB || w_f3 == F3_SH || w_f3 == F3_SW)
                               : (w_f3 == F3_LB || w_f3 == F3_LH || w_f3 == F3_LW ||
                                  w_f3 == F3_LBU || w_f3 == F3_LHU);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and load/store accesses onto one single-port RAM
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LATENCY      = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [3:0]        i_dm_mode,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_rvalid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_err,
    output logic              o_ram_en,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [3:0]        o_ram_mode,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(LATENCY + 1);
    state_t            r_state, w_state;
    logic              r_sel_dm, w_sel_dm, r_legal, w_legal, r_flushed, w_flushed;
    logic [SW-1:0]     r_starve, w_starve;
    logic [CW-1:0]     r_wait, w_wait;
    logic              r_if_gnt, w_if_gnt, r_if_rvalid, w_if_rvalid;
    logic              r_dm_gnt, w_dm_gnt, r_dm_rvalid, w_dm_rvalid, r_dm_err, w_dm_err;
    logic              r_ram_en, w_ram_en;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata, r_dm_rdata, w_dm_rdata;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic [3:0]        r_ram_mode, w_ram_mode;
    logic [DATA_W-1:0] r_ram_wdata, w_ram_wdata;
    logic              w_dm_legal, w_if_win;

    mem_mode_check u_mode_check (.i_mode(i_dm_mode), .o_legal(w_dm_legal));

    assign w_if_win = i_if_req && (!i_dm_req || r_starve == SW'(STARVE_LIMIT));

    always_comb begin
        w_state     = r_state;
        w_sel_dm    = r_sel_dm;
        w_legal     = r_legal;
        w_flushed   = r_flushed;
        w_starve    = r_starve;
        w_wait      = r_wait;
        w_if_gnt    = 1'b0;
        w_dm_gnt    = 1'b0;
        w_if_rvalid = 1'b0;
        w_dm_rvalid = 1'b0;
        w_dm_err    = 1'b0;
        w_if_rdata  = '0;
        w_dm_rdata  = '0;
        w_ram_en    = 1'b0;
        w_ram_addr  = r_ram_addr;
        w_ram_mode  = r_ram_mode;
        w_ram_wdata = r_ram_wdata;
        case (r_state)
            IDLE: if (i_if_req || i_dm_req) begin
                w_state     = ISSUE;
                w_sel_dm    = !w_if_win;
                w_legal     = w_if_win || w_dm_legal;
                w_flushed   = 1'b0;
                w_starve    = w_if_win ? '0 : (i_if_req ? r_starve + 1'b1 : r_starve);
                w_if_gnt    = w_if_win;
                w_dm_gnt    = !w_if_win;
                w_ram_en    = w_legal;
                w_ram_addr  = !w_legal ? '0 : (w_if_win ? i_if_addr : i_dm_addr);
                w_ram_mode  = !w_legal ? '0 : (w_if_win ? MODE_FETCH : i_dm_mode);
                w_ram_wdata = (!w_legal || w_if_win) ? '0 : i_dm_wdata;
            end
            ISSUE: begin
                w_flushed = r_flushed || (!r_sel_dm && i_if_flush);
                if (!r_legal) begin
                    w_state     = IDLE;
                    w_dm_rvalid = 1'b1;
                    w_dm_err    = 1'b1;
                end else if (LATENCY == 1) begin
                    w_state = RESP;
                end else begin
                    w_state = WAIT;
                    w_wait  = CW'(1);
                end
            end
            WAIT: begin
                w_flushed = r_flushed || (!r_sel_dm && i_if_flush);
                w_state   = (r_wait == CW'(LATENCY - 1)) ? RESP : WAIT;
                w_wait    = (r_wait == CW'(LATENCY - 1)) ? '0 : r_wait + 1'b1;
            end
            RESP: begin
                w_state     = IDLE;
                w_flushed   = 1'b0;
                w_ram_addr  = '0;
                w_ram_mode  = '0;
                w_ram_wdata = '0;
                w_dm_rvalid = r_sel_dm;
                w_dm_rdata  = (r_sel_dm && !r_ram_mode[0]) ? i_ram_rdata : '0;
                w_if_rvalid = !r_sel_dm && !r_flushed && !i_if_flush;
                w_if_rdata  = w_if_rvalid ? i_ram_rdata : '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sel_dm    <= 1'b0;
            r_legal     <= 1'b0;
            r_flushed   <= 1'b0;
            r_starve    <= '0;
            r_wait      <= '0;
            r_if_gnt    <= 1'b0;
            r_dm_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_dm_err    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_ram_en    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_mode  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_state     <= w_state;
            r_sel_dm    <= w_sel_dm;
            r_legal     <= w_legal;
            r_flushed   <= w_flushed;
            r_starve    <= w_starve;
            r_wait      <= w_wait;
            r_if_gnt    <= w_if_gnt;
            r_dm_gnt    <= w_dm_gnt;
            r_if_rvalid <= w_if_rvalid;
            r_dm_rvalid <= w_dm_rvalid;
            r_dm_err    <= w_dm_err;
            r_if_rdata  <= w_if_rdata;
            r_dm_rdata  <= w_dm_rdata;
            r_ram_en    <= w_ram_en;
            r_ram_addr  <= w_ram_addr;
            r_ram_mode  <= w_ram_mode;
            r_ram_wdata <= w_ram_wdata;
        end
    end

    assign o_if_gnt    = r_if_gnt;
    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_gnt    = r_dm_gnt;
    assign o_dm_rvalid = r_dm_rvalid;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_err    = r_dm_err;
    assign o_ram_en    = r_ram_en;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_mode  = r_ram_mode;
    assign o_ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for the memory port arbiter with a fixed-latency RAM model
module tb_mem_port_arbiter;
    localparam int LAT = 3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_mode = '0;
    logic        o_if_gnt, o_if_rvalid, o_dm_gnt, o_dm_rvalid, o_dm_err, o_ram_en;
    logic [31:0] o_if_rdata, o_dm_rdata, o_ram_addr, o_ram_wdata, ram_rdata;
    logic [3:0]  o_ram_mode;
    logic        any_out;
    int          n_vec = 0, n_err = 0;
    logic [31:0] if_q[$];
    logic [32:0] dm_q[$];
    logic [LAT-1:0] sh_v = '0;
    logic [31:0]    sh_d [LAT];

    mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dm_req(dm_req), .i_dm_addr(dm_addr), .i_dm_mode(dm_mode), .i_dm_wdata(dm_wdata),
        .o_dm_gnt(o_dm_gnt), .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata), .o_dm_err(o_dm_err),
        .o_ram_en(o_ram_en), .o_ram_addr(o_ram_addr), .o_ram_mode(o_ram_mode),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0050_0093 : {a[15:0], 16'hC0DE};
    endfunction

    always @(posedge clk) begin
        sh_v <= {sh_v[LAT-2:0], o_ram_en && !o_ram_mode[0]};
        sh_d[0] <= mem_data(o_ram_addr);
        for (int i = 1; i < LAT; i++) sh_d[i] <= sh_d[i-1];
    end
    assign ram_rdata = sh_v[LAT-1] ? sh_d[LAT-1] : 32'hBAD0_BAD0;
    assign any_out = |{o_if_gnt, o_if_rvalid, o_if_rdata, o_dm_gnt, o_dm_rvalid, o_dm_rdata,
                       o_dm_err, o_ram_en, o_ram_addr, o_ram_mode, o_ram_wdata};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (o_if_rvalid) begin
            if (if_q.size() == 0) chk("if_rvalid_spurious", o_if_rvalid, 0);
            else chk("if_rdata", o_if_rdata, if_q.pop_front());
        end
        if (o_dm_rvalid) begin
            if (dm_q.size() == 0) chk("dm_rvalid_spurious", o_dm_rvalid, 0);
            else chk("dm_resp", {o_dm_err, o_dm_rdata}, dm_q.pop_front());
        end
    end

    task automatic run_one(input bit dm, input logic [31:0] a, input logic [3:0] m,
                           input logic [31:0] wd, input int flush_at, input int rst_at,
                           output int gc, output int ec, output int rc,
                           output logic [31:0] ra, output logic [3:0] rm, output logic [31:0] rw);
        gc = -1; ec = -1; rc = -1; ra = '0; rm = '0; rw = '0;
        @(negedge clk);
        if (dm) begin dm_req = 1'b1; dm_addr = a; dm_mode = m; dm_wdata = wd; end
        else begin if_req = 1'b1; if_addr = a; end
        for (int k = 1; k <= LAT + 6; k++) begin
            @(negedge clk);
            if (gc < 0 && (dm ? o_dm_gnt : o_if_gnt)) begin
                gc = k;
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            if (ec < 0 && o_ram_en) begin ec = k; ra = o_ram_addr; rm = o_ram_mode; rw = o_ram_wdata; end
            if (rc < 0 && (dm ? o_dm_rvalid : o_if_rvalid)) rc = k;
            if_flush = (k == flush_at);
            if (k == rst_at) begin
                chk("pre_rst_ram_addr", o_ram_addr, a);
                rst_n = 1'b0;
                #1;
                chk("rst_async_outs", any_out, 0);
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            if (k == rst_at + 1) rst_n = 1'b1;
        end
        if_flush = 1'b0;
    endtask

    task automatic dm_case(input logic [31:0] a, input logic [3:0] m, input logic [31:0] wd, input int flush_at);
        int gc, ec, rc;
        logic [31:0] ra, rw;
        logic [3:0] rm;
        logic [2:0] f3;
        logic ok;
        f3 = m[3:1];
        ok = m[0] ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        dm_q.push_back({!ok, (ok && !m[0]) ? mem_data(a) : 32'h0});
        run_one(1'b1, a, m, wd, flush_at, 0, gc, ec, rc, ra, rm, rw);
        chk("dm_gnt_cycle", gc, 1);
        if (ok) begin
            chk("dm_en_cycle", ec, 1);
            chk("dm_ram_addr", ra, a);
            chk("dm_ram_mode", rm, m);
            chk("dm_ram_wdata", rw, wd);
            chk("dm_rvalid_cycle", rc, LAT + 2);
        end else begin
            chk("dm_illegal_no_en", ec, -1);
            chk("dm_illegal_rvalid_cycle", rc, 2);
        end
    endtask

    task automatic if_case(input logic [31:0] a, input int flush_at, input bit pre_flush);
        int gc, ec, rc;
        logic [31:0] ra, rw;
        logic [3:0] rm;
        if (flush_at == 0) if_q.push_back(mem_data(a));
        if_flush = pre_flush;
        run_one(1'b0, a, 4'h0, 32'h0, flush_at, 0, gc, ec, rc, ra, rm, rw);
        chk("if_gnt_cycle", gc, 1);
        chk("if_en_cycle", ec, 1);
        chk("if_ram_addr", ra, a);
        chk("if_ram_mode", rm, 4'b0100);
        chk("if_rvalid_cycle", rc, (flush_at == 0) ? LAT + 2 : -1);
    endtask

    initial begin
        int n, sc, gc, ec, rc;
        logic [31:0] ra, rw;
        logic [3:0] rm;
        logic exp_dm;
        #1 rst_n = 1'b0;
        #1 chk("reset_outs", any_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        if_case(32'h10, 0, 1'b0);
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_addr = 32'h90; dm_mode = 4'b0100; dm_wdata = '0;
        n = 0;
        sc = 0;
        for (int k = 0; k < 200 && n < 9; k++) begin
            @(negedge clk);
            if (o_if_gnt || o_dm_gnt) begin
                exp_dm = !if_req || sc != 3;
                sc = !exp_dm ? 0 : (if_req ? sc + 1 : sc);
                chk("gnt_order", {o_if_gnt, o_dm_gnt}, exp_dm ? 2'b01 : 2'b10);
                if (exp_dm) dm_q.push_back({1'b0, mem_data(32'h90)});
                else if_q.push_back(mem_data(32'h80));
                n++;
                if (n == 8) if_req = 1'b0;
                if (n == 9) dm_req = 1'b0;
            end
        end
        chk("arb_grant_count", n, 9);
        repeat (LAT + 4) @(negedge clk);
        dm_case(32'h20, 4'b0101, 32'hDEAD_BEEF, 0);
        dm_case(32'h24, 4'b0111, 32'h0, 0);
        dm_case(32'h28, 4'b1010, 32'h0, 0);
        dm_case(32'h2C, 4'b0110, 32'h0, 0);
        dm_case(32'h30, 4'b1001, 32'h1234_5678, 0);
        dm_case(32'h34, 4'b0000, 32'h0, 2);
        if_case(32'h40, 2, 1'b0);
        if_case(32'h44, 0, 1'b0);
        if_case(32'h48, 0, 1'b1);
        run_one(1'b0, 32'h50, 4'h0, 32'h0, 0, 2, gc, ec, rc, ra, rm, rw);
        chk("rst_no_stale_rvalid", rc, -1);
        if_case(32'h60, 0, 1'b0);
        repeat (LAT + 4) @(negedge clk);
        chk("if_queue_drained", if_q.size(), 0);
        chk("dm_queue_drained", dm_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between the fetch requester (IF) and the load/store requester (DM). The CPU is multi-cycle and has one RAM.
- Serialises accesses with one access outstanding at a time and a fixed RAM read latency.
- DM has priority. An anti-starvation counter guarantees fetch progress.
- Forwards the decoder's 4-bit ram mode {funct3, write} unchanged and rejects illegal modes.
- Honours a fetch flush when a branch or jump is taken.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- LATENCY, 1, cycles from the ram_en cycle to valid ram_rdata; must be >= 1.
- STARVE_LIMIT, 3, consecutive DM wins while IF is waiting before IF is forced to win; must be >= 1.

Ports:
- clk, in, 1, clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- if_req, in, 1, fetch request; held until if_gnt.
- if_addr, in, ADDR_W, fetch address.
- if_flush, in, 1, discard any in-flight fetch response (branch/jump taken).
- if_gnt, out, 1, one-cycle pulse: fetch accepted.
- if_rvalid, out, 1, one-cycle pulse: if_rdata valid.
- if_rdata, out, DATA_W, fetched instruction.
- dm_req, in, 1, data request; held until dm_gnt.
- dm_addr, in, ADDR_W, data address.
- dm_mode, in, 4, {funct3, we}.
- dm_wdata, in, DATA_W, store data.
- dm_gnt, out, 1, one-cycle pulse: data request accepted.
- dm_rvalid, out, 1, one-cycle pulse: load data valid or store acknowledged.
- dm_rdata, out, DATA_W, load data; 0 for stores and errors.
- dm_err, out, 1, qualifies dm_rvalid: illegal mode, no RAM access made.
- ram_en, out, 1, RAM access strobe.
- ram_addr, out, ADDR_W, RAM address.
- ram_mode, out, 4, RAM mode; IF always uses 4'b0100 (LW, read).
- ram_wdata, out, DATA_W, RAM write data.
- ram_rdata, in, DATA_W, RAM read data.

Behaviour:
- All outputs are registered. Reset (rst_n low, asynchronous) clears:
  - every output to 0;
  - state to IDLE;
  - starve_cnt and wait_cnt to 0;
  - the flushed flag.
- Reset asserted mid-access abandons that access; no rvalid is issued.
- States:
  - IDLE: sample requests.
  - ISSUE: gnt pulse, ram_en=1, address/mode/wdata driven from latched values.
  - WAIT: count LATENCY-1 cycles; skipped when LATENCY=1.
  - RESP: capture ram_rdata, return to IDLE.
- IDLE selection at a clock edge:
  - Only one requester active: that one wins.
  - Both active: DM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - DM win with IF also requesting: starve_cnt+1.
  - Any IF win: starve_cnt resets to 0.
  - Winner's address, mode and wdata are latched; next state is ISSUE.
- Timing for LATENCY=1, request first sampled at edge T:
  - Cycle T+1: gnt=1, ram_en=1.
  - Cycle T+2: RESP; ram_rdata sampled at its end.
  - Cycle T+3: rvalid=1, state IDLE, and a new request can be sampled.
  - Total request-to-rvalid latency is LATENCY+2 cycles. Throughput is one access per LATENCY+2 cycles.
- ram_en is high only in ISSUE. ram_addr, ram_mode and ram_wdata hold their latched values through ISSUE to RESP; they are 0 in IDLE.
- Illegal dm_mode:
  - Reads allow funct3 000, 001, 010, 100, 101. Writes allow only 000, 001, 010.
  - On an illegal mode: ISSUE pulses dm_gnt only; ram_en stays 0; WAIT/RESP are skipped.
  - The next cycle is IDLE with dm_rvalid=1, dm_err=1, dm_rdata=0.
- Stores: dm_rvalid pulses with dm_rdata=0 and dm_err=0.
- if_flush:
  - Sampled from ISSUE through RESP of an IF access; sets a flushed flag, and the IF rvalid is suppressed.
  - if_flush in IDLE has no effect on arbitration.
  - if_flush during a DM access is ignored.
- Requesters changing inputs before their gnt is undefined use; no check is required.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - MODE_FETCH = 4'b0100;
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- Sub-module mem_mode_check: combinational {funct3, we} -> legal flag. Reused later by the load/store unit.

Test Plan:
- Reset, then if_req=1, if_addr=0x10, ram_rdata=0x00500093 in RESP -> if_gnt at T+1; ram_en=1 with ram_addr=0x10 and ram_mode=4'b0100; if_rvalid=1 with if_rdata=0x00500093 at T+3.
- if_req and dm_req both held, dm_mode=4'b0100, STARVE_LIMIT=3 -> grant order DM, DM, DM, IF, DM, ...; starve_cnt returns to 0 after the IF grant.
- Store dm_mode=4'b0101, addr=0x20, wdata=0xDEADBEEF -> ram_mode=4'b0101 with matching addr/wdata in ISSUE; dm_rvalid=1, dm_rdata=0, dm_err=0.
- dm_mode=4'b0111 (illegal SD) -> dm_gnt pulse, ram_en never high, dm_rvalid=1 with dm_err=1 one cycle later.
- Fetch in flight and if_flush=1 during WAIT (LATENCY=3) -> no if_rvalid pulse; next IDLE accepts a new fetch normally.
- rst_n low during WAIT -> all outputs 0 immediately (asynchronous); after release, no stale rvalid pulse appears.
